// File: rtl/gate_exerciser_pkg.sv
// Shared types and constants for the 2-input AND gate exerciser:
// FSM states, vector count and the expected-output truth table.
package gate_exerciser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam int NUM_VECS = 4;
  localparam logic [1:0] LAST_VEC = 2'(NUM_VECS - 1);

  // Bit i is the AND output for {a,b} = i.
  localparam logic [NUM_VECS-1:0] AND_TRUTH = 4'b1000;

  function automatic logic expected_y(input logic [1:0] vec);
    return AND_TRUTH[vec];
  endfunction

endpackage

// File: rtl/gate_exerciser_settle.sv
// Down-counting settle timer: load sets the count, then it decrements to
// zero and holds there; expired is high whenever the count is zero.
module settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_exerciser.sv
// Drives all four input vectors into a 2-input AND gate, waits a settle time,
// checks each response and reports the result. Define GATE_EXERCISER_LOOP_EN for continuous looping with a stop input.
module gate_exerciser
  import gate_exerciser_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef GATE_EXERCISER_LOOP_EN
  input  logic             stop,
`endif
  input  logic             dut_y,
  output logic             dut_a,
  output logic             dut_b,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       fail_vec
);

  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [1:0]       vec;
  logic             load;
  logic             expired;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;
`ifdef GATE_EXERCISER_LOOP_EN
  logic             stop_req;
`endif

  assign load     = (state == APPLY);
  assign mismatch = (dut_y != expected_y(vec));
  assign err_next = (mismatch && (err_count != '1)) ? err_count + ERR_W'(1) : err_count;

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_value(SETTLE_LOAD),
    .expired   (expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      vec       <= '0;
      dut_a     <= 1'b0;
      dut_b     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
`ifdef GATE_EXERCISER_LOOP_EN
      stop_req  <= 1'b0;
`endif
    end else begin
`ifdef GATE_EXERCISER_LOOP_EN
      // stop may be a short pulse; remember it until the pass boundary.
      if (stop && busy) stop_req <= 1'b1;
`endif
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= APPLY;
            vec       <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
`ifdef GATE_EXERCISER_LOOP_EN
            stop_req  <= 1'b0;
`endif
          end
        end
        APPLY: begin
          dut_a <= vec[1];
          dut_b <= vec[0];
          done  <= 1'b0;
          state <= SETTLE;
        end
        SETTLE: begin
          if (expired) state <= SAMPLE;
        end
        SAMPLE: begin
          err_count <= err_next;
          // A zero count before this sample means this is the first mismatch.
          if (mismatch && (err_count == '0)) fail_vec <= vec;
          if (vec == LAST_VEC) begin
            done <= 1'b1;
            pass <= (err_next == '0);
`ifdef GATE_EXERCISER_LOOP_EN
            if (stop_req || stop) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= APPLY;
              vec   <= '0;
            end
`else
            state <= DONE;
            busy  <= 1'b0;
`endif
          end else begin
            vec   <= vec + 2'd1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_exerciser.sv
// Scoreboard bench for gate_exerciser: stimulus queues expected run results,
// per-instance monitors check them when done rises.
module tb_gate_exerciser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start4, start1, y4, y1;
  logic       a4, b4, busy4, done4, pass4;
  logic       a1, b1, busy1, done1, pass1;
  logic [7:0] err4, err1;
  logic [1:0] fv4, fv1;
  int         mode4;
`ifdef GATE_EXERCISER_LOOP_EN
  logic       stop4;
`endif

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       pass;
    int         err;
    logic [1:0] fv;
    logic       busy;
    int         at;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;

  // Gate under test for the main instance: 0 = AND, 1 = stuck at 1, 2 = OR.
  always_comb begin
    case (mode4)
      1:       y4 = 1'b1;
      2:       y4 = a4 | b4;
      default: y4 = a4 & b4;
    endcase
  end
  assign y1 = a1 & b1;

  gate_exerciser #(.SETTLE_CYCLES(4), .ERR_W(8)) u4 (
    .clk(clk), .rst(rst), .start(start4),
`ifdef GATE_EXERCISER_LOOP_EN
    .stop(stop4),
`endif
    .dut_y(y4), .dut_a(a4), .dut_b(b4), .busy(busy4), .done(done4),
    .pass(pass4), .err_count(err4), .fail_vec(fv4)
  );

  gate_exerciser #(.SETTLE_CYCLES(1), .ERR_W(8)) u1 (
    .clk(clk), .rst(rst), .start(start1),
`ifdef GATE_EXERCISER_LOOP_EN
    .stop(1'b1),
`endif
    .dut_y(y1), .dut_a(a1), .dut_b(b1), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  logic done4_q = 1'b0;
  logic done1_q = 1'b0;

  always @(negedge clk) begin : mon4
    exp_t e;
    if (done4 && !done4_q) begin
      chk("done4_expected", int'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("u4_pass", pass4, e.pass);
        chk("u4_err_count", err4, e.err);
        chk("u4_fail_vec", fv4, e.fv);
        chk("u4_busy", busy4, e.busy);
        chk("u4_done_cycle", cyc, e.at);
      end
    end
    done4_q = done4;
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (done1 && !done1_q) begin
      chk("done1_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("u1_pass", pass1, e.pass);
        chk("u1_err_count", err1, e.err);
        chk("u1_fail_vec", fv1, e.fv);
        chk("u1_busy", busy1, e.busy);
        chk("u1_done_cycle", cyc, e.at);
      end
    end
    done1_q = done1;
  end

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while ((q4.size() != 0 || q1.size() != 0) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q4.size() + q1.size(), 0);
    q4.delete();
    q1.delete();
  endtask

  // Run starts on the next posedge; done is expected 24 edges after that.
  task automatic run4(input int mode, input logic p, input int e, input logic [1:0] fv);
    mode4  = mode;
    start4 = 1'b1;
    q4.push_back('{p, e, fv, 1'b0, cyc + 25});
    @(negedge clk);
    start4 = 1'b0;
    wait_drain(200);
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, "_dut_a"}, a4, 0);
    chk({tag, "_dut_b"}, b4, 0);
    chk({tag, "_busy"}, busy4, 0);
    chk({tag, "_done"}, done4, 0);
    chk({tag, "_pass"}, pass4, 0);
    chk({tag, "_err_count"}, err4, 0);
    chk({tag, "_fail_vec"}, fv4, 0);
  endtask

  initial begin
    int t;
    rst    = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    mode4  = 0;
`ifdef GATE_EXERCISER_LOOP_EN
    stop4  = 1'b1;
`endif
    repeat (3) @(negedge clk);
    chk_zero4("reset");
    chk("reset_u1_busy", busy1, 0);
    rst = 1'b0;
    @(negedge clk);

    run4(0, 1'b1, 0, 2'b00);
    run4(1, 1'b0, 3, 2'b00);
    run4(2, 1'b0, 2, 2'b01);

    start1 = 1'b1;
    q1.push_back('{1'b1, 0, 2'b00, 1'b0, cyc + 13});
    @(negedge clk);
    start1 = 1'b0;
    wait_drain(100);

    // start pulsed again mid-run must not restart the run
    mode4  = 0;
    start4 = 1'b1;
    q4.push_back('{1'b1, 0, 2'b00, 1'b0, cyc + 25});
    @(negedge clk);
    start4 = 1'b0;
    repeat (9) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_drain(200);

    // start coincident with the DONE-entry edge is ignored
    start4 = 1'b1;
    t = cyc + 25;
    q4.push_back('{1'b1, 0, 2'b00, 1'b0, t});
    @(negedge clk);
    start4 = 1'b0;
    while (cyc < t - 1) @(negedge clk);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    chk("late_start_done_held", done4, 1);
    chk("late_start_not_busy", busy4, 0);
    wait_drain(10);
    run4(0, 1'b1, 0, 2'b00);

    // asynchronous reset while vector 2 is settling
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    repeat (15) @(negedge clk);
    chk("midrun_dut_a", a4, 1);
    chk("midrun_dut_b", b4, 0);
    chk("midrun_busy", busy4, 1);
    #1 rst = 1'b1;
    #1 chk_zero4("async_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run4(0, 1'b1, 0, 2'b00);

`ifdef GATE_EXERCISER_LOOP_EN
    stop4  = 1'b0;
    start4 = 1'b1;
    t = cyc;
    q4.push_back('{1'b1, 0, 2'b00, 1'b1, t + 25});
    q4.push_back('{1'b1, 0, 2'b00, 1'b1, t + 49});
    q4.push_back('{1'b1, 0, 2'b00, 1'b0, t + 73});
    @(negedge clk);
    start4 = 1'b0;
    while (cyc < t + 55) @(negedge clk);
    stop4 = 1'b1;
    @(negedge clk);
    stop4 = 1'b0;
    wait_drain(200);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
